// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, FSM states and default timings for the hazard controller.
// Optional stall counters are enabled by defining HAZARD_STALL_CNT_EN.
package hazard_ctrl_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam tuse_t TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // A source is hazardous if a live, non-$0 producer is still too far away.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input tuse_t      tuse,
    input logic [4:0] e_a3,
    input logic       e_we,
    input tnew_t      e_tnew,
    input logic [4:0] m_a3,
    input logic       m_we,
    input tnew_t      m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = e_we && (e_a3 == src) && (e_tnew > tuse);
    m_hit = m_we && (m_a3 == src) && (m_tnew > tuse);
    return (tuse != TUSE_NONE) && (src != 5'd0) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Multiply/divide occupancy timer: IDLE/BUSY FSM with a down-counter.
// md_busy and md_done are both registered.
module md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy,
  output logic o_done
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt   <= i_div ? CNT_W'(DIV_CYCLES)
                             : CNT_W'(MULT_CYCLES);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == BUSY);
  assign o_done = r_done;

  // The md stall in D keeps a second start from reaching E while busy.
  a_no_restart: assert property (
    @(posedge clk) disable iff (reset)
    !((r_state == BUSY) && i_start)
  );

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data stalls plus mult/div busy stall.
// Define HAZARD_STALL_CNT_EN to add saturating stall_cycles/md_stall_cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_A3,
  input  logic        E_we,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_A3,
  input  logic        M_we,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        md_busy,
  output logic        md_done
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_data_stall;
  logic w_md_stall;
  logic w_busy;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_start (E_md_start),
    .i_div   (E_md_div),
    .o_busy  (w_busy),
    .o_done  (md_done)
  );

  assign w_stall_rs = src_hazard(D_rs, D_tuse_rs,
                                 E_A3, E_we, E_tnew,
                                 M_A3, M_we, M_tnew);
  assign w_stall_rt = src_hazard(D_rt, D_tuse_rt,
                                 E_A3, E_we, E_tnew,
                                 M_A3, M_we, M_tnew);

  assign w_data_stall = w_stall_rs || w_stall_rt;
  // A start still in E counts as occupied for an md instruction in D.
  assign w_md_stall   = D_md && (w_busy || E_md_start);

  assign stall   = (w_data_stall || w_md_stall) && !reset;
  assign md_busy = w_busy;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_md_stall_cycles;
  logic        w_md_only;

  assign w_md_only = w_md_stall && !w_data_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles    <= '0;
      r_md_stall_cycles <= '0;
    end else begin
      if (stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_md_only && (r_md_stall_cycles != '1))
        r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for data stalls,
// directed sequences for the mult/div timer, reset and combined stalls.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt;
  logic [1:0] D_tuse_rs, D_tuse_rt;
  logic       D_md;
  logic [4:0] E_A3;
  logic       E_we;
  logic [1:0] E_tnew;
  logic [4:0] M_A3;
  logic       M_we;
  logic [1:0] M_tnew;
  logic       E_md_start, E_md_div;
  logic       stall, md_busy, md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
  logic [31:0] sc0, msc0;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_md       (D_md),
    .E_A3       (E_A3),
    .E_we       (E_we),
    .E_tnew     (E_tnew),
    .M_A3       (M_A3),
    .M_we       (M_we),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_done    (md_done)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tr;
    logic [1:0] tt;
    logic       md;
    logic [4:0] ea;
    logic       ew;
    logic [1:0] et;
    logic [4:0] ma;
    logic       mw;
    logic [1:0] mt;
    logic       st;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [1:0] tr, input logic [1:0] tt,
    input logic md,
    input logic [4:0] ea, input logic ew, input logic [1:0] et,
    input logic [4:0] ma, input logic mw, input logic [1:0] mt,
    input logic st
  );
    vec_t v;
    v.rs = rs; v.rt = rt; v.tr = tr; v.tt = tt; v.md = md;
    v.ea = ea; v.ew = ew; v.et = et;
    v.ma = ma; v.mw = mw; v.mt = mt; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_md = 0;
    E_A3 = 0; E_we = 0; E_tnew = 0;
    M_A3 = 0; M_we = 0; M_tnew = 0;
  endtask

  initial begin
    //            rs  rt tr tt md  ea ew et  ma mw mt  st
    vecs[0]  = mk( 8,  0, 1, 3, 0,  8, 1, 2,  0, 0, 0, 1);
    vecs[1]  = mk( 8,  0, 1, 3, 0,  0, 0, 0,  8, 1, 1, 0);
    vecs[2]  = mk( 0,  0, 0, 3, 0,  0, 1, 2,  0, 0, 0, 0);
    vecs[3]  = mk( 0,  9, 3, 0, 0,  0, 0, 0,  9, 1, 1, 1);
    vecs[4]  = mk( 8,  0, 3, 3, 0,  8, 1, 2,  8, 1, 1, 0);
    vecs[5]  = mk( 8,  0, 0, 3, 0,  8, 0, 2,  0, 0, 0, 0);
    vecs[6]  = mk( 8,  0, 0, 3, 0,  9, 1, 2,  0, 0, 0, 0);
    vecs[7]  = mk( 0,  5, 3, 1, 0,  5, 1, 2,  0, 0, 0, 1);
    vecs[8]  = mk( 0,  5, 3, 2, 0,  5, 1, 2,  0, 0, 0, 0);
    vecs[9]  = mk( 7,  0, 0, 3, 0,  7, 1, 1,  0, 0, 0, 1);
    vecs[10] = mk( 7,  0, 0, 3, 0,  7, 1, 0,  0, 0, 0, 0);
    vecs[11] = mk( 3,  4, 0, 0, 1,  5, 1, 2,  6, 1, 1, 0);
    vecs[12] = mk(31,  0, 0, 3, 0,  0, 0, 0, 31, 1, 1, 1);
    vecs[13] = mk( 0,  0, 0, 0, 0,  0, 1, 2,  0, 1, 1, 0);
    vecs[14] = mk( 2,  2, 1, 0, 0,  3, 1, 2,  2, 1, 2, 1);

    reset = 1'b1;
    E_md_start = 0; E_md_div = 0;
    clear_d();
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst_sc", stall_cycles, 32'd0);
    chk("rst_msc", md_stall_cycles, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Data-hazard table, timer idle
    for (int i = 0; i < 15; i++) begin
      D_rs = vecs[i].rs; D_rt = vecs[i].rt;
      D_tuse_rs = vecs[i].tr; D_tuse_rt = vecs[i].tt;
      D_md = vecs[i].md;
      E_A3 = vecs[i].ea; E_we = vecs[i].ew; E_tnew = vecs[i].et;
      M_A3 = vecs[i].ma; M_we = vecs[i].mw; M_tnew = vecs[i].mt;
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].st});
      tick();
    end

    // lw in E then in M
    clear_d();
    D_rs = 8; D_tuse_rs = 2'd1;
    E_A3 = 8; E_we = 1; E_tnew = 2'd2;
    #1;
    chk("lw_e_stall", {31'd0, stall}, 32'd1);
    tick();
    E_A3 = 0; E_we = 0; E_tnew = 0;
    M_A3 = 8; M_we = 1; M_tnew = 2'd1;
    #1;
    chk("lw_m_stall", {31'd0, stall}, 32'd0);
    tick();

    // mult: 5 busy cycles, D_md held
    clear_d();
    D_md = 1; E_md_start = 1; E_md_div = 0;
    #1;
    chk("mul_start_stall", {31'd0, stall}, 32'd1);
    chk("mul_start_busy", {31'd0, md_busy}, 32'd0);
    tick();
    E_md_start = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mul_busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mul_stall%0d", i), {31'd0, stall}, 32'd1);
      chk($sformatf("mul_done%0d", i), {31'd0, md_done}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
      sc0 = stall_cycles; msc0 = md_stall_cycles;
`endif
      tick();
`ifdef HAZARD_STALL_CNT_EN
      chk("mul_sc_inc", stall_cycles, sc0 + 32'd1);
      chk("mul_msc_inc", md_stall_cycles, msc0 + 32'd1);
`endif
      #1;
    end
    chk("mul_end_busy", {31'd0, md_busy}, 32'd0);
    chk("mul_end_done", {31'd0, md_done}, 32'd1);
    chk("mul_end_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mul_done_pulse", {31'd0, md_done}, 32'd0);

    // Data and md stall together
    D_rs = 8; D_tuse_rs = 2'd1;
    E_A3 = 8; E_we = 1; E_tnew = 2'd2;
    D_md = 1; E_md_start = 1; E_md_div = 0;
    #1;
    chk("both_stall", {31'd0, stall}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
    sc0 = stall_cycles; msc0 = md_stall_cycles;
`endif
    tick();
    E_md_start = 0;
`ifdef HAZARD_STALL_CNT_EN
    chk("both_sc_inc", stall_cycles, sc0 + 32'd1);
    chk("both_msc_hold", md_stall_cycles, msc0);
`endif
    clear_d();
    for (int i = 0; i < 6; i++) tick();
    chk("drain_busy", {31'd0, md_busy}, 32'd0);
    tick();

    // Reset masks a hazard; release restores it combinationally
    D_rs = 8; D_tuse_rs = 2'd0;
    E_A3 = 8; E_we = 1; E_tnew = 2'd1;
    reset = 1;
    #1;
    chk("rst_mask_stall", {31'd0, stall}, 32'd0);
    tick();
    reset = 0;
    #1;
    chk("rst_release_stall", {31'd0, stall}, 32'd1);
    tick();
    clear_d();

    // div, then reset on busy cycle 4
    D_md = 1; E_md_start = 1; E_md_div = 1;
    tick();
    E_md_start = 0;
    tick(); tick(); tick();
    chk("div_busy4", {31'd0, md_busy}, 32'd1);
    reset = 1;
    #1;
    chk("div_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    reset = 0;
    #1;
    chk("div_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("div_rst_md_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("div_no_done%0d", i), {31'd0, md_done}, 32'd0);
      chk($sformatf("div_idle%0d", i), {31'd0, md_busy}, 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
